ifetch_unit: RTL

Instruction fetch stage that sits directly upstream of the PC register. It drives that register's `D` and enable with the next sequential or redirected PC. It fetches instructions from instruction memory over a request/acknowledge handshake and buffers them in a small FIFO for decode. Redirects from branches and jumps flush the buffer, and any in-flight memory response is discarded.

---
 rtl/ifetch_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: drives the PC register, fetches over a req/ack memory port
// and buffers words in a prefetch FIFO. Optional stall counter: define IFETCH_PERF_CNT_EN.
module ifetch_unit #(
  parameter int NrOfBits  = 32,
  parameter int FifoDepth = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NrOfBits-1:0] PCQ,
  output logic [NrOfBits-1:0] NextPC,
  output logic                PCLoad,
  input  logic                Redirect,
  input  logic [NrOfBits-1:0] RedirectPC,
  output logic                imem_req,
  output logic [NrOfBits-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [NrOfBits-1:0] imem_rdata,
  output logic [NrOfBits-1:0] Instr,
  output logic [NrOfBits-1:0] InstrPC,
  output logic                InstrValid,
  input  logic                InstrReady,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]         StallCount,
`endif
  output logic [1:0]          dbg_state
);

  // Handshakes: imem_req/imem_addr are held until the single-cycle imem_ack;
  // a FIFO entry leaves when InstrValid && InstrReady on a rising edge.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int PW = (FifoDepth > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FifoDepth);

  state_t state, state_next;

  logic [NrOfBits-1:0] fifo_instr [FifoDepth];
  logic [NrOfBits-1:0] fifo_pc    [FifoDepth];
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count, occ_next;
  logic                push, pop, issue;

  assign dbg_state  = state;
  assign InstrValid = (count != '0);
  assign Instr      = fifo_instr[rd_ptr];
  assign InstrPC    = fifo_pc[rd_ptr];

  always_comb begin
    pop      = InstrValid & InstrReady & ~Redirect;
    push     = (state == S_REQ) & imem_ack & ~Redirect;
    occ_next = count + CW'(push) - CW'(pop);
    issue    = ~Redirect & (occ_next < DEPTH) &
               ((state == S_IDLE) | ((state == S_REQ) & imem_ack));
  end

  // Redirect always wins the PC register; otherwise it advances only on issue.
  always_comb begin
    NextPC = PCQ + NrOfBits'(4);
    PCLoad = 1'b0;
    if (Redirect) begin
      NextPC = RedirectPC & ~NrOfBits'(3);
      PCLoad = ~Reset;
    end else if (issue) begin
      PCLoad = ~Reset;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (issue) state_next = S_REQ;
      end
      S_REQ: begin
        if (Redirect) state_next = imem_ack ? S_IDLE : S_DRAIN;
        else if (imem_ack) state_next = issue ? S_REQ : S_IDLE;
      end
      S_DRAIN: begin
        if (imem_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      state    <= state_next;
      imem_req <= (state_next != S_IDLE);
      if (issue) imem_addr <= PCQ;
      if (Redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= occ_next;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge Clock) begin
    if (push && !Reset) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= imem_addr;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      StallCount <= '0;
    end else if (InstrReady && !InstrValid && (StallCount != 32'hFFFF_FFFF)) begin
      StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule
